// File: rtl/cylon_show_scheduler.sv
// cylon_show_scheduler
//   Autonomous show controller for the cylon display. Steps through a
//   4-entry writable playlist (mode, speed, brightness, duration), fading
//   brightness out, switching entry and fading back in between entries.
//   A manual override passes man_* straight through, and btn_next skips
//   the running entry.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   manual            level, 1 = override playlist with man_* inputs
//   man_mode/speed/brightness  manual values
//   btn_next          single-cycle pulse, skip to next entry (RUN only)
//   wr_en/wr_addr/wr_data      playlist write port
//                     wr_data = {mode[1:0], speed[3:0], brightness[3:0], duration[5:0]}
//   mode/speed/brightness      registered drive to the cylon
//   step              index of the active entry
//   fading            high in FADE_OUT, SWITCH and FADE_IN
module cylon_show_scheduler #(
  parameter int CLOCK_CYCLES_PER_SECOND = 100_000_000,
  parameter int FADE_CLKS               = 6_250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        manual,
  input  logic [1:0]  man_mode,
  input  logic [3:0]  man_speed,
  input  logic [3:0]  man_brightness,
  input  logic        btn_next,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic [1:0]  mode,
  output logic [3:0]  speed,
  output logic [3:0]  brightness,
  output logic [1:0]  step,
  output logic        fading
);

  localparam int PW = (CLOCK_CYCLES_PER_SECOND > 1) ? $clog2(CLOCK_CYCLES_PER_SECOND) : 1;
  localparam int FW = (FADE_CLKS > 1) ? $clog2(FADE_CLKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCK_CYCLES_PER_SECOND - 1);
  localparam logic [FW-1:0] FADE_LAST  = FW'(FADE_CLKS - 1);

  localparam logic [15:0] DEF0 = {2'd0, 4'd0, 4'd15, 6'd10};
  localparam logic [15:0] DEF1 = {2'd1, 4'd2, 4'd15, 6'd5};
  localparam logic [15:0] DEF2 = {2'd2, 4'd2, 4'd15, 6'd5};
  localparam logic [15:0] DEF3 = {2'd3, 4'd4, 4'd8,  6'd10};

  typedef enum logic [2:0] {
    S_FADE_OUT,
    S_SWITCH,
    S_FADE_IN,
    S_RUN,
    S_MANUAL
  } state_t;

  state_t          r_state;
  logic [15:0]     r_play [4];
  logic [1:0]      r_step;
  logic [1:0]      r_mode;
  logic [3:0]      r_speed;
  logic [3:0]      r_bright;
  logic            r_fading;
  logic [3:0]      r_tgt_bright;
  logic [5:0]      r_dur;
  logic [FW-1:0]   r_fade_cnt;
  logic [PW-1:0]   r_presc;
  logic [5:0]      r_secs;

  logic [1:0]      w_next_idx;
  logic [15:0]     w_entry;
  logic [5:0]      w_entry_dur;

  // SWITCH reads the registered playlist, so a same-cycle write to the
  // same address is seen only by a later load.
  assign w_next_idx  = r_step + 2'd1;
  assign w_entry     = r_play[w_next_idx];
  assign w_entry_dur = (w_entry[5:0] == 6'd0) ? 6'd1 : w_entry[5:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_play[0] <= DEF0;
      r_play[1] <= DEF1;
      r_play[2] <= DEF2;
      r_play[3] <= DEF3;
    end else if (wr_en) begin
      r_play[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_FADE_IN;
      r_step       <= '0;
      r_mode       <= '0;
      r_speed      <= '0;
      r_bright     <= '0;
      r_fading     <= 1'b1;
      r_tgt_bright <= DEF0[9:6];
      r_dur        <= DEF0[5:0];
      r_fade_cnt   <= '0;
      r_presc      <= '0;
      r_secs       <= '0;
    end else if (manual) begin
      r_state    <= S_MANUAL;
      r_mode     <= man_mode;
      r_speed    <= man_speed;
      r_bright   <= man_brightness;
      r_fading   <= 1'b0;
      r_fade_cnt <= '0;
    end else begin
      case (r_state)
        S_FADE_OUT: begin
          if (r_bright == 4'd0) begin
            r_state    <= S_SWITCH;
            r_fade_cnt <= '0;
          end else if (r_fade_cnt == FADE_LAST) begin
            r_fade_cnt <= '0;
            r_bright   <= r_bright - 4'd1;
            if (r_bright == 4'd1) begin
              r_state <= S_SWITCH;
            end
          end else begin
            r_fade_cnt <= r_fade_cnt + 1'b1;
          end
        end

        S_SWITCH: begin
          r_step       <= w_next_idx;
          r_mode       <= w_entry[15:14];
          r_speed      <= w_entry[13:10];
          r_tgt_bright <= w_entry[9:6];
          r_dur        <= w_entry_dur;
          r_bright     <= '0;
          r_fade_cnt   <= '0;
          r_state      <= S_FADE_IN;
        end

        S_FADE_IN: begin
          if (r_bright == r_tgt_bright) begin
            r_state    <= S_RUN;
            r_fading   <= 1'b0;
            r_fade_cnt <= '0;
            r_presc    <= '0;
            r_secs     <= '0;
          end else if (r_fade_cnt == FADE_LAST) begin
            r_fade_cnt <= '0;
            r_bright   <= r_bright + 4'd1;
            if (r_bright + 4'd1 == r_tgt_bright) begin
              r_state  <= S_RUN;
              r_fading <= 1'b0;
              r_presc  <= '0;
              r_secs   <= '0;
            end
          end else begin
            r_fade_cnt <= r_fade_cnt + 1'b1;
          end
        end

        S_RUN: begin
          // A skip on the final tick also lands here, giving one FADE_OUT.
          if (btn_next) begin
            r_state    <= S_FADE_OUT;
            r_fading   <= 1'b1;
            r_fade_cnt <= '0;
          end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            r_secs  <= r_secs + 6'd1;
            if (r_secs + 6'd1 == r_dur) begin
              r_state    <= S_FADE_OUT;
              r_fading   <= 1'b1;
              r_fade_cnt <= '0;
            end
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end

        S_MANUAL: begin
          // Release: fade out from whatever manual brightness was last set.
          r_state    <= S_FADE_OUT;
          r_fading   <= 1'b1;
          r_fade_cnt <= '0;
        end

        default: begin
          r_state    <= S_FADE_OUT;
          r_fading   <= 1'b1;
          r_fade_cnt <= '0;
        end
      endcase
    end
  end

  assign mode       = r_mode;
  assign speed      = r_speed;
  assign brightness = r_bright;
  assign step       = r_step;
  assign fading     = r_fading;

endmodule

// File: tb/tb_cylon_show_scheduler.sv
// Directed bench for cylon_show_scheduler with CLOCK_CYCLES_PER_SECOND=10
// and FADE_CLKS=2. Edge numbers below count rising clock edges since the
// most recent reset release.
module tb_cylon_show_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        manual;
  logic [1:0]  man_mode;
  logic [3:0]  man_speed;
  logic [3:0]  man_brightness;
  logic        btn_next;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  mode;
  logic [3:0]  speed;
  logic [3:0]  brightness;
  logic [1:0]  step;
  logic        fading;

  int n_tests = 0;
  int n_fail  = 0;
  int t_edge  = 0;

  cylon_show_scheduler #(
    .CLOCK_CYCLES_PER_SECOND(10),
    .FADE_CLKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .manual(manual),
    .man_mode(man_mode),
    .man_speed(man_speed),
    .man_brightness(man_brightness),
    .btn_next(btn_next),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .mode(mode),
    .speed(speed),
    .brightness(brightness),
    .step(step),
    .fading(fading)
  );

  always #5 clk = ~clk;

  task automatic goto(input int e);
    repeat (e - t_edge) @(posedge clk);
    #1;
    t_edge = e;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] e_step, input logic [1:0] e_mode,
                         input logic [3:0] e_speed, input logic [3:0] e_bright, input logic e_fading);
    chk($sformatf("%s.step", tag),   {14'd0, step},       {14'd0, e_step});
    chk($sformatf("%s.mode", tag),   {14'd0, mode},       {14'd0, e_mode});
    chk($sformatf("%s.speed", tag),  {12'd0, speed},      {12'd0, e_speed});
    chk($sformatf("%s.bright", tag), {12'd0, brightness}, {12'd0, e_bright});
    chk($sformatf("%s.fading", tag), {15'd0, fading},     {15'd0, e_fading});
  endtask

  initial begin
    rst = 1'b1; manual = 1'b0; man_mode = '0; man_speed = '0; man_brightness = '0;
    btn_next = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset state.
    @(posedge clk); #1;
    chk_all("reset", 2'd0, 2'd0, 4'd0, 4'd0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; t_edge = 0;

    // Entry 0 fade-in 0 -> 15 in 30 cycles, RUN 100, fade-out 30, SWITCH.
    goto(29);  chk_all("e0_fadein_29", 2'd0, 2'd0, 4'd0, 4'd14, 1'b1);
    goto(30);  chk_all("e0_run_30",    2'd0, 2'd0, 4'd0, 4'd15, 1'b0);
    goto(129); chk("e0_run_129.fading", {15'd0, fading}, 16'd0);
    goto(130); chk_all("e0_fo_130",    2'd0, 2'd0, 4'd0, 4'd15, 1'b1);
    goto(160); chk_all("e0_switch_160", 2'd0, 2'd0, 4'd0, 4'd0, 1'b1);
    goto(161); chk_all("e1_load_161",  2'd1, 2'd1, 4'd2, 4'd0, 1'b1);

    // Entries 1, 2, 3 with defaults, then wrap to 0.
    goto(272); chk_all("e2_load_272",  2'd2, 2'd2, 4'd2, 4'd0, 1'b1);
    goto(383); chk_all("e3_load_383",  2'd3, 2'd3, 4'd4, 4'd0, 1'b1);
    goto(398); chk_all("e3_fadein_398", 2'd3, 2'd3, 4'd4, 4'd7, 1'b1);
    goto(399); chk_all("e3_run_399",   2'd3, 2'd3, 4'd4, 4'd8, 1'b0);
    goto(499); chk_all("e3_fo_499",    2'd3, 2'd3, 4'd4, 4'd8, 1'b1);
    goto(515); chk_all("e3_switch_515", 2'd3, 2'd3, 4'd4, 4'd0, 1'b1);
    goto(516); chk_all("wrap_516",     2'd0, 2'd0, 4'd0, 4'd0, 1'b1);
    goto(546); chk_all("e0_run_546",   2'd0, 2'd0, 4'd0, 4'd15, 1'b0);

    // Write entry 1 = {2,7,4,0} during RUN of entry 0.
    goto(548); wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h9D00;
    goto(549); wr_en = 1'b0;
    goto(645); chk("wr_e0_run_645.fading", {15'd0, fading}, 16'd0);
    goto(646); chk("wr_e0_fo_646.fading",  {15'd0, fading}, 16'd1);
    goto(677); chk_all("wr_e1_load_677", 2'd1, 2'd2, 4'd7, 4'd0, 1'b1);
    goto(684); chk_all("wr_e1_fi_684",   2'd1, 2'd2, 4'd7, 4'd3, 1'b1);
    goto(685); chk_all("wr_e1_run_685",  2'd1, 2'd2, 4'd7, 4'd4, 1'b0);
    goto(694); chk("wr_e1_run_694.fading", {15'd0, fading}, 16'd0);
    goto(695); chk_all("wr_e1_fo_695",   2'd1, 2'd2, 4'd7, 4'd4, 1'b1);
    goto(704); chk_all("e2_load_704",    2'd2, 2'd2, 4'd2, 4'd0, 1'b1);

    // btn_next 3 cycles into RUN of entry 2; second pulse in FADE_OUT ignored.
    goto(734); chk_all("e2_run_734",     2'd2, 2'd2, 4'd2, 4'd15, 1'b0);
    goto(737); btn_next = 1'b1;
    goto(738); btn_next = 1'b0;
    chk_all("btn_fo_738", 2'd2, 2'd2, 4'd2, 4'd15, 1'b1);
    goto(741); btn_next = 1'b1;
    goto(742); btn_next = 1'b0;
    chk_all("btn2_742", 2'd2, 2'd2, 4'd2, 4'd13, 1'b1);
    goto(767); chk_all("btn_fo_767",     2'd2, 2'd2, 4'd2, 4'd1, 1'b1);
    goto(768); chk_all("btn_switch_768", 2'd2, 2'd2, 4'd2, 4'd0, 1'b1);
    goto(769); chk_all("e3_load_769",    2'd3, 2'd3, 4'd4, 4'd0, 1'b1);

    // Manual override in the middle of entry 3 fade-in.
    goto(773); chk("man_pre_773.bright", {12'd0, brightness}, 16'd2);
    manual = 1'b1; man_mode = 2'd1; man_speed = 4'd9; man_brightness = 4'd6;
    goto(774); chk_all("man_774", 2'd3, 2'd1, 4'd9, 4'd6, 1'b0);
    man_mode = 2'd2; man_speed = 4'd3; man_brightness = 4'd5;
    #1; chk_all("man_latency", 2'd3, 2'd1, 4'd9, 4'd6, 1'b0);
    goto(775); chk_all("man_775", 2'd3, 2'd2, 4'd3, 4'd5, 1'b0);
    manual = 1'b0;
    goto(776); chk_all("man_rel_776", 2'd3, 2'd2, 4'd3, 4'd5, 1'b1);
    goto(785); chk_all("man_fo_785",  2'd3, 2'd2, 4'd3, 4'd1, 1'b1);
    goto(786); chk_all("man_sw_786",  2'd3, 2'd2, 4'd3, 4'd0, 1'b1);
    goto(787); chk_all("man_next_787", 2'd0, 2'd0, 4'd0, 4'd0, 1'b1);

    // Write entry 0, then reset mid-RUN of entry 2.
    goto(975); chk_all("e2_load_975", 2'd2, 2'd2, 4'd2, 4'd0, 1'b1);
    goto(980); wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'h4E42;
    goto(981); wr_en = 1'b0;
    goto(1020); chk_all("e2_run_1020", 2'd2, 2'd2, 4'd2, 4'd15, 1'b0);
    rst = 1'b1;
    #1; chk_all("async_rst", 2'd0, 2'd0, 4'd0, 4'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; t_edge = 0;

    goto(30);  chk_all("rst_run_30", 2'd0, 2'd0, 4'd0, 4'd15, 1'b0);
    goto(130); chk("rst_fo_130.fading", {15'd0, fading}, 16'd1);
    goto(161); chk_all("rst_e1_161", 2'd1, 2'd1, 4'd2, 4'd0, 1'b1);

    // SWITCH load coinciding with a write to the same address uses old value.
    goto(515); chk_all("rst_e3_sw_515", 2'd3, 2'd3, 4'd4, 4'd0, 1'b1);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'hFCFF;
    goto(516); wr_en = 1'b0;
    chk_all("rst_wrap_516", 2'd0, 2'd0, 4'd0, 4'd0, 1'b1);
    goto(546); chk_all("rst_e0_run_546", 2'd0, 2'd0, 4'd0, 4'd15, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
